// File: rtl/lfsr_seq_ctrl_if.sv
// lfsr_seq_ctrl_if: host/consumer handshake bundle for the LFSR sequencing controller.
interface lfsr_seq_ctrl_if #(parameter int CNT_W = 8);
  logic             start;
  logic [3:0]       seed;
  logic [CNT_W-1:0] len;
  logic             abort;
  logic             out_ready;
  logic             out_valid;
  logic [3:0]       out_data;
  logic             busy;
  logic             done;
  logic             err;
  modport master (output start, seed, len, abort, out_ready,
                  input  out_valid, out_data, busy, done, err);
  modport slave  (input  start, seed, len, abort, out_ready,
                  output out_valid, out_data, busy, done, err);
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: streams len states of a 4-bit Fibonacci LFSR over valid/ready, with done/err/abort.
module lfsr_seq_ctrl #(parameter int CNT_W = 8) (
  input logic            clk,
  input logic            rst,
  lfsr_seq_ctrl_if.slave bus
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t           r_state, w_next;
  logic [3:0]       r_q;
  logic [CNT_W-1:0] r_rem;
  logic             r_done, r_err;
  logic             w_bad, w_go, w_step, w_last;
  always_comb begin
    w_bad  = bus.seed == 4'h0 || bus.len == '0;
    w_go   = r_state == IDLE && bus.start && !w_bad;
    // abort wins over a same-cycle handshake, so the state never advances on it
    w_step = r_state == EMIT && bus.out_ready && !bus.abort;
    w_last = w_step && r_rem == CNT_W'(1);
    w_next = w_go ? EMIT : (r_state == EMIT && (bus.abort || w_last)) ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_q     <= 4'h0;
      r_rem   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_last;
      r_err   <= r_state == IDLE && bus.start && w_bad;
      if (w_go) begin
        r_q   <= bus.seed;
        r_rem <= bus.len;
      end else if (w_step) begin
        r_q   <= {r_q[3] ^ r_q[2], r_q[1:0], r_q[3]};
        r_rem <= r_rem - CNT_W'(1);
      end
    end
  end
  assign bus.out_valid = r_state == EMIT;
  assign bus.busy      = r_state == EMIT;
  assign bus.out_data  = r_q;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb_lfsr_seq_ctrl: vector table plus hand sequences; beats checked against a queue-based scoreboard.
module tb_lfsr_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  lfsr_seq_ctrl_if #(.CNT_W(8)) bus();
  lfsr_seq_ctrl #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  logic [3:0] sb[$];
  typedef struct {
    logic [3:0] seed;
    logic [7:0] len;
    logic       exp_err;
  } vec_t;
  vec_t vecs[7];
  function automatic logic [3:0] nxt(input logic [3:0] q);
    return {q[3] ^ q[2], q[1], q[0], q[3]};
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // A beat is consumed on handshake, and also on an abort cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("done_err_excl", {31'b0, bus.done & bus.err}, 0);
      if (bus.out_valid && (bus.out_ready || bus.abort)) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_extra got %0h exp none at %0t", bus.out_data, $time);
        end else chk("beat_data", bus.out_data, sb.pop_front());
      end
    end
  end
  task automatic do_start(input logic [3:0] s, input logic [7:0] l);
    logic [3:0] q;
    bus.start = 1'b1;
    bus.seed  = s;
    bus.len   = l;
    if (s != 4'h0 && l != 8'h0) begin
      q = s;
      for (int i = 0; i < int'(l); i++) begin
        sb.push_back(q);
        q = nxt(q);
      end
    end
    tick();
    bus.start = 1'b0;
  endtask
  task automatic finish_run(input int l);
    int n = 0;
    while (!bus.done && n < l + 20) begin
      tick();
      n++;
    end
    chk("done_latency", n, l);
    chk("done_busy", bus.busy, 0);
    chk("done_valid", bus.out_valid, 0);
    chk("sb_empty", sb.size(), 0);
    tick();
    chk("done_pulse_1cyc", bus.done, 0);
  endtask
  task automatic check_idle_zero(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_data"}, bus.out_data, 0);
  endtask
  logic [5:0] bp_ready = 6'b101001;
  logic [3:0] bp_data[6] = '{4'h9, 4'hB, 4'hB, 4'hB, 4'hF, 4'hF};
  int hs0;
  initial begin
    vecs[0] = '{4'h1, 8'd4, 1'b0};
    vecs[1] = '{4'h0, 8'd5, 1'b1};
    vecs[2] = '{4'h3, 8'd0, 1'b1};
    vecs[3] = '{4'h5, 8'd7, 1'b0};
    vecs[4] = '{4'h1, 8'd16, 1'b0};
    vecs[5] = '{4'hC, 8'd1, 1'b0};
    vecs[6] = '{4'h0, 8'd0, 1'b1};
    bus.start = 1'b0; bus.seed = 4'h0; bus.len = 8'h0; bus.abort = 1'b0; bus.out_ready = 1'b1;
    tick();
    tick();
    check_idle_zero("reset");
    rst = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_idle_busy", bus.busy, 0);
    for (int v = 0; v < 7; v++) begin
      do_start(vecs[v].seed, vecs[v].len);
      chk("vec_busy", bus.busy, !vecs[v].exp_err);
      chk("vec_valid", bus.out_valid, !vecs[v].exp_err);
      chk("vec_err", bus.err, vecs[v].exp_err);
      if (vecs[v].exp_err) begin
        tick();
        chk("err_pulse_1cyc", bus.err, 0);
        chk("err_busy", bus.busy, 0);
      end else begin
        chk("vec_first", bus.out_data, vecs[v].seed);
        finish_run(int'(vecs[v].len));
      end
    end
    // backpressure, with an ignored bad start mid-run
    hs0 = hs_cnt;
    do_start(4'h9, 8'd3);
    for (int c = 0; c < 6; c++) begin
      bus.out_ready = bp_ready[c];
      bus.start = c == 1;
      chk("bp_data", bus.out_data, bp_data[c]);
      chk("bp_valid", bus.out_valid, 1);
      tick();
      bus.start = 1'b0;
      if (c == 1) chk("start_in_emit_err", bus.err, 0);
    end
    bus.out_ready = 1'b1;
    chk("bp_done", bus.done, 1);
    chk("bp_handshakes", hs_cnt - hs0, 3);
    chk("bp_sb_empty", sb.size(), 0);
    tick();
    // abort on the 3rd handshake
    do_start(4'h1, 8'd10);
    tick();
    tick();
    chk("abort_pre_data", bus.out_data, 4'h4);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    sb.delete();
    tick();
    chk("abort_done_late", bus.done, 0);
    do_start(4'hA, 8'd5);
    chk("post_abort_first", bus.out_data, 4'hA);
    finish_run(5);
    // back-to-back: new start on the done cycle
    do_start(4'h2, 8'd2);
    tick();
    tick();
    chk("b2b_done", bus.done, 1);
    do_start(4'h6, 8'd2);
    chk("b2b_busy", bus.busy, 1);
    chk("b2b_first", bus.out_data, 4'h6);
    finish_run(2);
    // reset during the 2nd beat
    do_start(4'h1, 8'd4);
    tick();
    chk("rst_pre_data", bus.out_data, 4'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("midrst");
    sb.delete();
    do_start(4'h1, 8'd4);
    chk("post_rst_first", bus.out_data, 4'h1);
    finish_run(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
